// File: rtl/keypad_pkg.sv
// keypad_pkg: shared definitions for the matrix keypad scanner.
//   - key class constants (NONE..RESET) carried on keyClass
//   - 5-bit event codes {enable, info} for the letter keys
//   - scanner FSM state type
//   - keymap(): key index (row*COLS + col) -> {class, code}
package keypad_pkg;

    localparam logic [2:0] ClsNone     = 3'd0;
    localparam logic [2:0] ClsNumber   = 3'd1;
    localparam logic [2:0] ClsOperator = 3'd2;
    localparam logic [2:0] ClsEqual    = 3'd3;
    localparam logic [2:0] ClsClear    = 3'd4;
    localparam logic [2:0] ClsReset    = 3'd5;

    localparam logic [4:0] CodeNone = 5'b00000;
    localparam logic [4:0] CodeF    = 5'b11111;
    localparam logic [4:0] CodeE    = 5'b11110;
    localparam logic [4:0] CodeD    = 5'b11101;
    localparam logic [4:0] CodeC    = 5'b11100;
    localparam logic [4:0] CodeB    = 5'b11011;
    localparam logic [4:0] CodeA    = 5'b11010;

    typedef enum logic [1:0] {
        StScan,
        StDebounce,
        StPressed
    } state_e;

    typedef struct packed {
        logic [2:0] cls;
        logic [4:0] code;
    } key_info_t;

    // Row-major layout: 1 2 3 F / 4 5 6 E / 7 8 9 D / A 0 B C.
    // Digits encode as {1, bcd}.
    function automatic key_info_t keymap(input logic [3:0] index);
        key_info_t info;
        case (index)
            4'd0:    info = '{cls: ClsNumber,   code: 5'b10001};
            4'd1:    info = '{cls: ClsNumber,   code: 5'b10010};
            4'd2:    info = '{cls: ClsNumber,   code: 5'b10011};
            4'd3:    info = '{cls: ClsOperator, code: CodeF};
            4'd4:    info = '{cls: ClsNumber,   code: 5'b10100};
            4'd5:    info = '{cls: ClsNumber,   code: 5'b10101};
            4'd6:    info = '{cls: ClsNumber,   code: 5'b10110};
            4'd7:    info = '{cls: ClsOperator, code: CodeE};
            4'd8:    info = '{cls: ClsNumber,   code: 5'b10111};
            4'd9:    info = '{cls: ClsNumber,   code: 5'b11000};
            4'd10:   info = '{cls: ClsNumber,   code: 5'b11001};
            4'd11:   info = '{cls: ClsOperator, code: CodeD};
            4'd12:   info = '{cls: ClsReset,    code: CodeA};
            4'd13:   info = '{cls: ClsNumber,   code: 5'b10000};
            4'd14:   info = '{cls: ClsEqual,    code: CodeB};
            default: info = '{cls: ClsClear,    code: CodeC};
        endcase
        return info;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad pins plus the decoded key-event bus.
//   rowSense  raw rows, active low (driven by the keypad)
//   colDrive  column strobes, active low, one bit low at a time
//   keyValid  one-cycle pulse per accepted press
//   keyClass  key class tag, keyCode 5-bit event code
//   keyHeld   high from accepted press to accepted release
// master: the scanner side; slave: keypad pins / event consumer side.
interface keypad_scanner_if #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 4
);
    logic [ROWS-1:0] rowSense;
    logic [COLS-1:0] colDrive;
    logic            keyValid;
    logic [2:0]      keyClass;
    logic [4:0]      keyCode;
    logic            keyHeld;

    modport master (
        input  rowSense,
        output colDrive, keyValid, keyClass, keyCode, keyHeld
    );

    modport slave (
        output rowSense,
        input  colDrive, keyValid, keyClass, keyCode, keyHeld
    );
endinterface

// File: rtl/keypad_sync.sv
// keypad_sync: Width-bit two-flop synchroniser with asynchronous active-low reset.
//   clk_i   sampling clock
//   rst_ni  asynchronous reset, active low; both stages load ResetVal
//   d_i     asynchronous input
//   q_o     synchronised output (2 cycles of latency)
module keypad_sync #(
    parameter int unsigned     Width    = 4,
    parameter logic [Width-1:0] ResetVal = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);
    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= ResetVal;
            sync_q <= ResetVal;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes keypad columns, samples rows once per SCAN_DIV window,
// debounces press and release over DEBOUNCE samples and emits one event per press.
//   newClock  system clock (rising edge)
//   resetN    asynchronous reset, active low
//   bus       keypad_scanner_if master: rowSense in; colDrive, keyValid,
//             keyClass, keyCode, keyHeld out
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 8
) (
    input  logic             newClock,
    input  logic             resetN,
    keypad_scanner_if.master bus
);
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned DivW = $clog2(SCAN_DIV);
    localparam int unsigned CntW = $clog2(DEBOUNCE + 1);

    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [ColW-1:0] ColLast = ColW'(COLS - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE);

    logic [ROWS-1:0] rows_sync;
    logic [ROWS-1:0] rows_low;
    logic            one_low;
    logic            none_low;
    logic [RowW-1:0] row_idx;
    logic            sample;
    logic [ColW-1:0] col_next;
    logic [COLS-1:0] col_drive;
    key_info_t       key_info;

    state_e          state_q, state_d;
    logic [DivW-1:0] div_q;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] rel_q, rel_d;
    logic            valid_q, valid_d;
    logic [2:0]      class_q, class_d;
    logic [4:0]      code_q, code_d;
    logic            held_q, held_d;

    // Resets to all-ones so the idle (no key) level is seen during and after reset.
    keypad_sync #(
        .Width    (ROWS),
        .ResetVal ({ROWS{1'b1}})
    ) u_sync (
        .clk_i  (newClock),
        .rst_ni (resetN),
        .d_i    (bus.rowSense),
        .q_o    (rows_sync)
    );

    always_comb begin
        rows_low = ~rows_sync;
        none_low = (rows_low == '0);
        // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
        one_low  = !none_low && ((rows_low & (rows_low - ROWS'(1))) == '0);
        row_idx  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (rows_low[r]) row_idx = RowW'(r);
        end
    end

    assign sample   = (div_q == DivLast);
    assign col_next = (col_q == ColLast) ? '0 : col_q + ColW'(1);
    assign key_info = keymap(4'(row_q) * 4'(COLS) + 4'(col_q));

    always_comb begin
        col_drive        = '1;
        col_drive[col_q] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        valid_d = 1'b0;
        class_d = class_q;
        code_d  = code_q;
        held_d  = held_q;

        if (sample) begin
            unique case (state_q)
                StScan: begin
                    if (one_low) begin
                        row_d   = row_idx;
                        cnt_d   = CntW'(1);
                        state_d = StDebounce;
                    end else begin
                        col_d = col_next;
                    end
                end
                StDebounce: begin
                    if (one_low && (row_idx == row_q)) begin
                        if (cnt_q + CntW'(1) == CntLast) begin
                            cnt_d   = '0;
                            valid_d = 1'b1;
                            class_d = key_info.cls;
                            code_d  = key_info.code;
                            held_d  = 1'b1;
                            state_d = StPressed;
                        end else begin
                            cnt_d = cnt_q + CntW'(1);
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_next;
                        state_d = StScan;
                    end
                end
                StPressed: begin
                    // Any low row on the frozen column, including a second key, holds the press.
                    if (none_low) begin
                        if (rel_q + CntW'(1) == CntLast) begin
                            rel_d   = '0;
                            held_d  = 1'b0;
                            class_d = ClsNone;
                            code_d  = CodeNone;
                            col_d   = col_next;
                            state_d = StScan;
                        end else begin
                            rel_d = rel_q + CntW'(1);
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = StScan;
            endcase
        end
    end

    always_ff @(posedge newClock or negedge resetN) begin
        if (!resetN) begin
            state_q <= StScan;
            div_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            rel_q   <= '0;
            valid_q <= 1'b0;
            class_q <= ClsNone;
            code_q  <= CodeNone;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= sample ? '0 : div_q + DivW'(1);
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            valid_q <= valid_d;
            class_q <= class_d;
            code_q  <= code_d;
            held_q  <= held_d;
        end
    end

    assign bus.colDrive = col_drive;
    assign bus.keyValid = valid_q;
    assign bus.keyClass = class_q;
    assign bus.keyCode  = code_q;
    assign bus.keyHeld  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed, table-driven bench for keypad_scanner with a
// behavioural 4x4 key matrix (pressed[] mask) closing rows onto driven columns.
module tb_keypad_scanner;
    localparam int S = 8;  // SCAN_DIV
    localparam int D = 4;  // DEBOUNCE

    logic        newClock = 1'b0;
    logic        resetN   = 1'b1;
    logic [15:0] pressed  = '0;
    logic [3:0]  rows;

    int          checks    = 0;
    int          failures  = 0;
    int          ev_count  = 0;
    logic [2:0]  ev_class  = '0;
    logic [4:0]  ev_code   = '0;

    typedef struct {
        string      name;
        int         key;
        logic [2:0] cls;
        logic [4:0] code;
    } vec_t;

    vec_t vecs[8];

    keypad_scanner_if #(.ROWS(4), .COLS(4)) kif ();

    keypad_scanner #(
        .ROWS     (4),
        .COLS     (4),
        .SCAN_DIV (S),
        .DEBOUNCE (D)
    ) dut (
        .newClock (newClock),
        .resetN   (resetN),
        .bus      (kif)
    );

    always #5 newClock = ~newClock;

    always_comb begin
        rows = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kif.colDrive[c]) rows[r] = 1'b0;
            end
        end
    end
    assign kif.rowSense = rows;

    always @(negedge newClock) begin
        if (kif.keyValid === 1'b1) begin
            ev_count = ev_count + 1;
            ev_class = kif.keyClass;
            ev_code  = kif.keyCode;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge newClock);
    endtask

    // Leaves resetN released exactly at a falling edge, before rising edge 1.
    task automatic do_reset();
        @(negedge newClock);
        #2 resetN = 1'b0;
        wait_neg(2);
        resetN = 1'b1;
    endtask

    function automatic logic [3:0] col_pat(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

    initial begin
        int base;
        logic [3:0] c0;

        vecs[0] = '{"key5", 5,  3'd1, 5'b10101};
        vecs[1] = '{"key9", 10, 3'd1, 5'b11001};
        vecs[2] = '{"key0", 13, 3'd1, 5'b10000};
        vecs[3] = '{"keyE", 7,  3'd2, 5'b11110};
        vecs[4] = '{"keyD", 11, 3'd2, 5'b11101};
        vecs[5] = '{"keyC", 15, 3'd4, 5'b11100};
        vecs[6] = '{"keyB", 14, 3'd3, 5'b11011};
        vecs[7] = '{"keyA", 12, 3'd5, 5'b11010};

        // Reset state.
        do_reset();
        check("rst_col",   32'(kif.colDrive), 32'(4'b1110));
        check("rst_valid", 32'(kif.keyValid), 32'(0));
        check("rst_class", 32'(kif.keyClass), 32'(0));
        check("rst_code",  32'(kif.keyCode),  32'(0));
        check("rst_held",  32'(kif.keyHeld),  32'(0));

        // Idle: three full scans, column advances on every S-th edge.
        base = ev_count;
        for (int k = 1; k <= 12; k++) begin
            wait_neg(S - 1);
            check("idle_col_hold", 32'(kif.colDrive), 32'(col_pat((k - 1) % 4)));
            wait_neg(1);
            check("idle_col_step", 32'(kif.colDrive), 32'(col_pat(k % 4)));
        end
        check("idle_events", 32'(ev_count - base), 32'(0));

        // Exact latency: key "1" held through reset, detected at edge S, valid after edge D*S.
        pressed = 16'h0001;
        do_reset();
        base = ev_count;
        wait_neg(D * S - 1);
        check("lat_valid_early", 32'(kif.keyValid), 32'(0));
        check("lat_held_early",  32'(kif.keyHeld),  32'(0));
        wait_neg(1);
        check("lat_valid", 32'(kif.keyValid), 32'(1));
        check("lat_held",  32'(kif.keyHeld),  32'(1));
        check("lat_class", 32'(kif.keyClass), 32'(1));
        check("lat_code",  32'(kif.keyCode),  32'(5'b10001));
        wait_neg(1);
        check("lat_valid_pulse", 32'(kif.keyValid), 32'(0));
        wait_neg(7);              // edge 40
        pressed = '0;             // first released sample at edge 48, D-th at 72
        wait_neg(31);             // edge 71
        check("rel_held_late", 32'(kif.keyHeld), 32'(1));
        wait_neg(1);              // edge 72
        check("rel_held_drop", 32'(kif.keyHeld),  32'(0));
        check("rel_class",     32'(kif.keyClass), 32'(0));
        check("rel_code",      32'(kif.keyCode),  32'(0));
        check("lat_events",    32'(ev_count - base), 32'(1));
        wait_neg(2 * S);

        // Table: every key class, press-hold-release.
        for (int i = 0; i < 8; i++) begin
            base = ev_count;
            pressed = 16'(1) << vecs[i].key;
            wait_neg(20 * S);
            check({vecs[i].name, "_events"},  32'(ev_count - base), 32'(1));
            check({vecs[i].name, "_evclass"}, 32'(ev_class),        32'(vecs[i].cls));
            check({vecs[i].name, "_evcode"},  32'(ev_code),         32'(vecs[i].code));
            check({vecs[i].name, "_class"},   32'(kif.keyClass),    32'(vecs[i].cls));
            check({vecs[i].name, "_code"},    32'(kif.keyCode),     32'(vecs[i].code));
            check({vecs[i].name, "_held"},    32'(kif.keyHeld),     32'(1));
            pressed = '0;
            wait_neg(8 * S);
            check({vecs[i].name, "_rel_held"},  32'(kif.keyHeld),  32'(0));
            check({vecs[i].name, "_rel_class"}, 32'(kif.keyClass), 32'(0));
            check({vecs[i].name, "_rel_code"},  32'(kif.keyCode),  32'(0));
            check({vecs[i].name, "_rel_events"}, 32'(ev_count - base), 32'(1));
        end

        // Short bounce alone on "B": at most 2 matching samples, no event.
        base = ev_count;
        pressed = 16'(1) << 14;
        wait_neg(2 * S - 4);
        pressed = '0;
        wait_neg(10 * S);
        check("bounce_short_events", 32'(ev_count - base), 32'(0));

        // Three bounces on "B", then stable.
        for (int i = 0; i < 3; i++) begin
            pressed = 16'(1) << 14;
            wait_neg(12);
            pressed = '0;
            wait_neg(12);
        end
        pressed = 16'(1) << 14;
        wait_neg(20 * S);
        check("bounce_events", 32'(ev_count - base), 32'(1));
        check("bounce_class",  32'(ev_class), 32'(3));
        check("bounce_code",   32'(ev_code),  32'(5'b11011));
        pressed = '0;
        wait_neg(8 * S);
        check("bounce_rel_held", 32'(kif.keyHeld), 32'(0));

        // Ghost: rows 0 and 2 low on column 0 ("1" and "7").
        base = ev_count;
        pressed = 16'h0101;
        wait_neg(20 * S);
        check("ghost_events", 32'(ev_count - base), 32'(0));
        check("ghost_held",   32'(kif.keyHeld), 32'(0));
        c0 = kif.colDrive;
        wait_neg(S);
        check("ghost_scanning", 32'(kif.colDrive != c0), 32'(1));
        pressed = '0;
        wait_neg(2 * S);

        // Asynchronous reset while "F" is held, then re-detection after release of reset.
        pressed = 16'(1) << 3;
        wait_neg(20 * S);
        check("f_held_pre", 32'(kif.keyHeld),  32'(1));
        check("f_class_pre", 32'(kif.keyClass), 32'(2));
        @(negedge newClock);
        #2 resetN = 1'b0;
        #1;
        check("arst_held",  32'(kif.keyHeld),  32'(0));
        check("arst_class", 32'(kif.keyClass), 32'(0));
        check("arst_code",  32'(kif.keyCode),  32'(0));
        check("arst_valid", 32'(kif.keyValid), 32'(0));
        check("arst_col",   32'(kif.colDrive), 32'(4'b1110));
        wait_neg(2);
        base = ev_count;
        resetN = 1'b1;
        wait_neg(20 * S);
        check("f_events", 32'(ev_count - base), 32'(1));
        check("f_class",  32'(ev_class), 32'(2));
        check("f_code",   32'(ev_code),  32'(5'b11111));
        check("f_held",   32'(kif.keyHeld), 32'(1));
        pressed = '0;
        wait_neg(8 * S);

        // Hold "A", add "0": ignored until "A" is released.
        base = ev_count;
        pressed = 16'(1) << 12;
        wait_neg(20 * S);
        check("a_events", 32'(ev_count - base), 32'(1));
        check("a_class",  32'(ev_class), 32'(5));
        check("a_code",   32'(ev_code),  32'(5'b11010));
        pressed = pressed | (16'(1) << 13);
        wait_neg(20 * S);
        check("a0_events", 32'(ev_count - base), 32'(1));
        check("a0_class",  32'(kif.keyClass), 32'(5));
        check("a0_held",   32'(kif.keyHeld),  32'(1));
        pressed = 16'(1) << 13;
        wait_neg(20 * S);
        check("zero_events", 32'(ev_count - base), 32'(2));
        check("zero_class",  32'(ev_class), 32'(1));
        check("zero_code",   32'(ev_code),  32'(5'b10000));
        pressed = '0;
        wait_neg(8 * S);
        check("zero_rel_held", 32'(kif.keyHeld), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a ROWS x COLS matrix keypad by strobing columns and sampling rows, debounces every press and release, and emits exactly one decoded key event per physical press. It replaces the level-driven combinational decoder that sits between the keypad pins and the calculator control logic. Event codes keep the existing 5-bit format: enable bit plus 4 information bits. Each event also carries a key-class tag and a one-cycle valid strobe.

## Interface
- ROWS, 4, number of row sense lines; ROWS*COLS <= 16
- COLS, 4, number of column drive lines
- SCAN_DIV, 1000, clock cycles each column is held; must be >= 4
- DEBOUNCE, 8, consecutive matching samples required to accept a press or a release; must be >= 2
- newClock  in  1  system clock; all logic is on the rising edge
- resetN  in  1  asynchronous, active-low reset
- rowSense  in  ROWS  raw keypad rows, active low, asynchronous to newClock
- colDrive  out  COLS  column strobes, active low, exactly one bit low at a time
- keyValid  out  1  one-cycle pulse on an accepted press
- keyClass  out  3  0 NONE, 1 NUMBER, 2 OPERATOR, 3 EQUAL, 4 CLEAR, 5 RESET
- keyCode  out  5  {1, info}: digit 0-9 gives 1_0000..1_1001; F/E/D give 11111/11110/11101; B gives 11011; C gives 11100; A gives 11010
- keyHeld  out  1  high from the accepted press until the accepted release

## Operation
- rowSense passes through a 2-flop synchroniser. A sample is taken on the last cycle of each SCAN_DIV window.
- Key index = row*COLS + col, where row 0 / col 0 is the top-left key. The default 4x4 map, row-major, is: 1 2 3 F / 4 5 6 E / 7 8 9 D / A 0 B C.
- State SCAN: colDrive walks col 0..COLS-1 and wraps, one column per SCAN_DIV window. A sample with exactly one row low freezes the column, loads cnt=1 and moves to DEBOUNCE. A sample with no row low, or more than one row low (ghost), advances to the next column.
- State DEBOUNCE: each further sample showing the same single row increments cnt. When cnt reaches DEBOUNCE: register keyClass/keyCode, pulse keyValid for one cycle, set keyHeld, go to PRESSED. Any differing sample clears cnt, advances the column and returns to SCAN with no event.
- State PRESSED: the column stays frozen. Samples with no row low increment relCnt; any other sample clears relCnt. When relCnt reaches DEBOUNCE: clear keyHeld, set keyClass=0 and keyCode=0, advance the column, go to SCAN.
- keyClass/keyCode remain stable while keyHeld=1. They are 0 otherwise.
- Reset, asserted at any time including mid-debounce or mid-hold: state SCAN, column 0, colDrive = all ones with bit 0 low, keyValid=0, keyClass=0, keyCode=0, keyHeld=0, all counters 0. No event is generated on reset release.

## Timing
- First-detect sample at cycle T. keyValid is high in cycle T + (DEBOUNCE-1)*SCAN_DIV + 1. keyHeld rises in the same cycle.
- keyHeld falls 1 cycle after the DEBOUNCE-th consecutive released sample.
- Pin-to-sample latency is 2 cycles of synchroniser. colDrive changes on the cycle after a window's sample, so rows have >= SCAN_DIV-2 cycles to settle.
- Minimum spacing between keyValid pulses is 2*DEBOUNCE*SCAN_DIV cycles.
- A second key pressed while one is held is ignored. It is detected only after release, if still pressed at that time.

## Structure
- Package keypad_pkg holds:
  - key class constants (NONE..RESET)
  - the 5-bit code constants
  - the state enum (SCAN, DEBOUNCE, PRESSED)
  - a function keymap(index) returning {class, code}
- Sub-module keypad_sync (parametrised-width 2-flop synchroniser with async active-low reset) handles rowSense.
- Scan counter, FSM, debounce counters and output registers live in keypad_scanner.

## Test plan
- Reset, then run idle with rowSense=4'b1111 for 3 full scans: colDrive cycles 1110 -> 1101 -> 1011 -> 0111 every SCAN_DIV cycles; keyValid never pulses.
- Hold key "5" (row 1 low while col 1 driven) for 20 sample periods: exactly one keyValid, keyClass=1, keyCode=10101, keyHeld=1. After release, keyHeld drops DEBOUNCE samples later.
- Press "B" with 3 bounce toggles inside the debounce window, then stable: exactly one keyValid, keyClass=3, keyCode=11011. A bounce shorter than DEBOUNCE samples alone produces no event.
- Rows 0 and 2 low together on col 0 (ghost): no event, and scanning continues.
- Assert resetN mid-PRESSED on key "F": all outputs drop to reset values asynchronously. After resetN deasserts with "F" still held, one new event arrives with keyClass=2, keyCode=11111.
- Hold "A", then also press "0": one event only (keyClass=5, keyCode=11010). After "A" is released, one event arrives with keyClass=1, keyCode=10000.
